// File: rtl/nonogram_pkg.sv
// Shared types and default sizes for the nonogram line-option queues.
//   OPT_W     : option/header word width
//   MAX_LINES : maximum lines per axis
//   CNT_W     : per-line option count width
package nonogram_pkg;

    localparam int OPT_W     = 16;
    localparam int MAX_LINES = 11;
    localparam int CNT_W     = 7;

    typedef struct packed {
        logic             is_header;
        logic [OPT_W-1:0] data;
    } q_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } q_state_t;

endpackage

// File: rtl/opt_ring_ram.sv
// Circular register array with two ordered write ports and one read port.
//   wr0_en/wr0_data : first write, lands at the write pointer
//   wr1_en/wr1_data : second write (only honoured with wr0_en), lands at wptr+1
//   rd_en           : advance the head (caller guarantees !empty)
//   rd_data         : word at the head (fall-through, undefined while empty)
//   occ / empty     : occupancy and empty flag
// DEPTH must be a power of two; pointers wrap naturally.
module opt_ring_ram #(
    parameter  int W     = 17,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr0_en,
    input  logic [W-1:0]  wr0_data,
    input  logic          wr1_en,
    input  logic [W-1:0]  wr1_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   occ,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_nx1;
    logic [AW:0]   occ_q, occ_d;
    logic          wr1_act;

    assign wr1_act  = wr0_en && wr1_en;
    assign wptr_nx1 = wptr_q + 1'b1;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr0_en) begin
            wptr_d = wptr_q + AW'(wr1_act ? 2 : 1);
        end
        if (rd_en) begin
            rptr_d = rptr_q + 1'b1;
        end
        occ_d = occ_q + (AW+1)'(wr0_en) + (AW+1)'(wr1_act) - (AW+1)'(rd_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // Storage needs no reset: occupancy gates everything read from it.
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            mem_q[wptr_q] <= wr0_data;
        end
        if (wr1_act) begin
            mem_q[wptr_nx1] <= wr1_data;
        end
    end

    assign rd_data = mem_q[rptr_q];
    assign occ     = occ_q;
    assign empty   = (occ_q == '0);

endmodule

// File: rtl/line_option_queue.sv
// Circular option store for one solver axis.
//   load_valid/load_data/load_is_header/load_done : one-shot loader
//   rd_en, dout, dout_is_header, empty              : fall-through pop to solver
//   pb_valid/pb_data                                : survivor put-back
//   old_options_amnt                                : packed per-line counts
//   started, round_done                             : status pulses
//   no_progress, overflow                           : sticky status
module line_option_queue #(
    parameter int OPT_W     = nonogram_pkg::OPT_W,
    parameter int MAX_LINES = nonogram_pkg::MAX_LINES,
    parameter int DEPTH     = 256,
    parameter int CNT_W     = nonogram_pkg::CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_valid,
    input  logic [OPT_W-1:0]           load_data,
    input  logic                       load_is_header,
    input  logic                       load_done,
    input  logic                       rd_en,
    output logic [OPT_W-1:0]           dout,
    output logic                       dout_is_header,
    output logic                       empty,
    input  logic                       pb_valid,
    input  logic [OPT_W-1:0]           pb_data,
    output logic [MAX_LINES*CNT_W-1:0] old_options_amnt,
    output logic                       started,
    output logic                       round_done,
    output logic                       no_progress,
    output logic                       overflow
);

    import nonogram_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int SW = CNT_W + 4;

    q_state_t         state_q, state_d;
    logic [3:0]       cur_line_q, cur_line_d, prev_line_q, prev_line_d;
    logic             cur_valid_q, cur_valid_d, prev_valid_q, prev_valid_d;
    logic [CNT_W-1:0] accum_q, accum_d, accum_inc, fin;
    logic [CNT_W-1:0] cnt_q [MAX_LINES];
    logic [CNT_W-1:0] cnt_d [MAX_LINES];
    logic             seen0_q, seen0_d;
    logic [SW-1:0]    sum_prev_q, sum_prev_d, sum_cur_q, sum_cur_d, sum_fin;
    logic             started_q, started_d, round_done_q, round_done_d;
    logic             no_progress_q, no_progress_d, overflow_q, overflow_d;

    logic             wr0_en, wr1_en, pop, hdr_pop, pb_ok, hdr_ok;
    logic [OPT_W:0]   wr0_data, wr1_data, rd_word;
    logic [AW:0]      occ;
    logic [AW+1:0]    free;
    logic             empty_w;

    opt_ring_ram #(.W(OPT_W + 1), .DEPTH(DEPTH)) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (pop),
        .rd_data  (rd_word),
        .occ      (occ),
        .empty    (empty_w)
    );

    always_comb begin
        state_d       = state_q;
        cur_line_d    = cur_line_q;
        cur_valid_d   = cur_valid_q;
        prev_line_d   = prev_line_q;
        prev_valid_d  = prev_valid_q;
        accum_d       = accum_q;
        cnt_d         = cnt_q;
        seen0_d       = seen0_q;
        sum_prev_d    = sum_prev_q;
        sum_cur_d     = sum_cur_q;
        started_d     = 1'b0;
        round_done_d  = 1'b0;
        no_progress_d = no_progress_q;
        overflow_d    = overflow_q;
        wr0_en        = 1'b0;
        wr0_data      = '0;
        wr1_en        = 1'b0;
        wr1_data      = '0;
        pop           = 1'b0;
        hdr_pop       = 1'b0;
        pb_ok         = 1'b0;
        hdr_ok        = 1'b0;
        accum_inc     = accum_q;
        fin           = '0;
        sum_fin       = sum_cur_q;
        free          = (AW+2)'(DEPTH) - (AW+2)'(occ);

        case (state_q)
            IDLE, LOAD: begin
                // The word that wakes the queue from IDLE is also stored.
                if (load_valid) begin
                    state_d = LOAD;
                    if (free != '0) begin
                        wr0_en   = 1'b1;
                        wr0_data = {load_is_header, load_data};
                        if (load_is_header) begin
                            cur_line_d  = load_data[3:0];
                            cur_valid_d = (32'(load_data[3:0]) < MAX_LINES);
                        end else if (cur_valid_q && cnt_q[cur_line_q] != '1) begin
                            cnt_d[cur_line_q] = cnt_q[cur_line_q] + 1'b1;
                        end
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (state_q == LOAD && load_done) begin
                    state_d   = RUN;
                    started_d = 1'b1;
                end
            end

            RUN: begin
                pop     = rd_en && !empty_w;
                hdr_pop = pop && rd_word[OPT_W];
                free    = free + (AW+2)'(pop);
                // Put-back has priority for the free slots; the header goes last.
                pb_ok   = pb_valid && (free != '0);
                hdr_ok  = hdr_pop && (free >= (AW+2)'(pb_ok ? 2 : 1));
                if ((pb_valid && !pb_ok) || (hdr_pop && !hdr_ok)) begin
                    overflow_d = 1'b1;
                end
                if (pb_ok) begin
                    wr0_en   = 1'b1;
                    wr0_data = {1'b0, pb_data};
                    wr1_en   = hdr_ok;
                    wr1_data = rd_word;
                end else if (hdr_ok) begin
                    wr0_en   = 1'b1;
                    wr0_data = rd_word;
                end

                if (pb_ok && accum_q != '1) begin
                    accum_inc = accum_q + 1'b1;
                end

                if (hdr_pop) begin
                    // A put-back in the same cycle belongs to the line being closed.
                    if (prev_valid_q && 32'(prev_line_q) < MAX_LINES) begin
                        cnt_d[prev_line_q] = accum_inc;
                        fin                = accum_inc;
                    end
                    sum_fin      = sum_cur_q + SW'(fin);
                    accum_d      = '0;
                    prev_line_d  = rd_word[3:0];
                    prev_valid_d = 1'b1;
                    sum_cur_d    = sum_fin;
                    if (rd_word[3:0] == 4'd0) begin
                        seen0_d   = 1'b1;
                        sum_cur_d = '0;
                        if (seen0_q) begin
                            round_done_d = 1'b1;
                            if (sum_fin == sum_prev_q) begin
                                no_progress_d = 1'b1;
                            end
                            sum_prev_d = sum_fin;
                        end
                    end
                end else begin
                    accum_d = accum_inc;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cur_line_q    <= '0;
            cur_valid_q   <= 1'b1;
            prev_line_q   <= '0;
            prev_valid_q  <= 1'b0;
            accum_q       <= '0;
            for (int unsigned i = 0; i < MAX_LINES; i++) begin
                cnt_q[i] <= '0;
            end
            seen0_q       <= 1'b0;
            sum_prev_q    <= '0;
            sum_cur_q     <= '0;
            started_q     <= 1'b0;
            round_done_q  <= 1'b0;
            no_progress_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_line_q    <= cur_line_d;
            cur_valid_q   <= cur_valid_d;
            prev_line_q   <= prev_line_d;
            prev_valid_q  <= prev_valid_d;
            accum_q       <= accum_d;
            cnt_q         <= cnt_d;
            seen0_q       <= seen0_d;
            sum_prev_q    <= sum_prev_d;
            sum_cur_q     <= sum_cur_d;
            started_q     <= started_d;
            round_done_q  <= round_done_d;
            no_progress_q <= no_progress_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        old_options_amnt = '0;
        for (int unsigned i = 0; i < MAX_LINES; i++) begin
            old_options_amnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign dout           = empty_w ? '0 : rd_word[OPT_W-1:0];
    assign dout_is_header = !empty_w && rd_word[OPT_W];
    assign empty          = empty_w;
    assign started        = started_q;
    assign round_done     = round_done_q;
    assign no_progress    = no_progress_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_line_option_queue.sv
module tb_line_option_queue;

    localparam int OPT_W     = 16;
    localparam int MAX_LINES = 11;
    localparam int CNT_W     = 7;
    localparam int DEPTH     = 256;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       load_valid, load_is_header, load_done;
    logic [OPT_W-1:0]           load_data;
    logic                       rd_en, pb_valid;
    logic [OPT_W-1:0]           pb_data;
    logic [OPT_W-1:0]           dout;
    logic                       dout_is_header, empty;
    logic [MAX_LINES*CNT_W-1:0] old_options_amnt;
    logic                       started, round_done, no_progress, overflow;

    int checks = 0;
    int errors = 0;
    logic [OPT_W:0] sb[$];   // expected queue contents, head first
    logic ovf_exp = 1'b0;

    line_option_queue #(
        .OPT_W(OPT_W), .MAX_LINES(MAX_LINES), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_data(load_data),
        .load_is_header(load_is_header), .load_done(load_done),
        .rd_en(rd_en), .dout(dout), .dout_is_header(dout_is_header), .empty(empty),
        .pb_valid(pb_valid), .pb_data(pb_data),
        .old_options_amnt(old_options_amnt),
        .started(started), .round_done(round_done),
        .no_progress(no_progress), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] cnt(input int i);
        return old_options_amnt[i*CNT_W +: CNT_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic hdr, input logic [OPT_W-1:0] d, input logic rd);
        load_valid     = 1'b1;
        load_is_header = hdr;
        load_data      = d;
        rd_en          = rd;
        pb_valid       = rd;
        pb_data        = 16'hDEAD;
        if (sb.size() < DEPTH) sb.push_back({hdr, d});
        tick();
        load_valid = 1'b0;
        rd_en      = 1'b0;
        pb_valid   = 1'b0;
    endtask

    task automatic finish_load();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    // One RUN cycle: optional pop (checked against the scoreboard head) and put-back.
    task automatic step(input logic rd, input logic pb, input logic [OPT_W-1:0] d);
        logic [OPT_W:0] e;
        logic hp;
        hp       = 1'b0;
        e        = '0;
        rd_en    = rd;
        pb_valid = pb;
        pb_data  = d;
        if (rd) begin
            check("empty_at_pop", {31'b0, empty}, {31'b0, sb.size() == 0});
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pop_word", {15'b0, dout_is_header, dout}, {15'b0, e});
                hp = e[OPT_W];
            end
        end
        if (pb) begin
            if (sb.size() < DEPTH) sb.push_back({1'b0, d});
            else ovf_exp = 1'b1;
        end
        if (hp) begin
            if (sb.size() < DEPTH) sb.push_back(e);
            else ovf_exp = 1'b1;
        end
        tick();
        rd_en    = 1'b0;
        pb_valid = 1'b0;
    endtask

    task automatic load_test_set();
        load(1'b1, 16'h0000, 1'b1);   // rd_en/pb_valid must be ignored while loading
        load(1'b0, 16'h0003, 1'b0);
        load(1'b0, 16'h0006, 1'b0);
        load(1'b0, 16'h000C, 1'b0);
        load(1'b1, 16'h0001, 1'b0);
        load(1'b0, 16'h0003, 1'b0);
        check("started_before_done", {31'b0, started}, 32'd0);
        finish_load();
        check("started_pulse", {31'b0, started}, 32'd1);
        check("cnt0_loaded", {25'b0, cnt(0)}, 32'd3);
        check("cnt1_loaded", {25'b0, cnt(1)}, 32'd1);
        check("head_is_h0", {15'b0, dout_is_header, dout}, {15'b0, 1'b1, 16'h0000});
        tick();
        check("started_once", {31'b0, started}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        load_valid = 1'b0; load_is_header = 1'b0; load_done = 1'b0; load_data = '0;
        rd_en = 1'b0; pb_valid = 1'b0; pb_data = '0;
        tick();
        tick();
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_dout", {16'b0, dout}, 32'd0);
        check("rst_counts", old_options_amnt[31:0] | {20'b0, old_options_amnt[76:65]}, 32'd0);
        check("rst_flags", {28'b0, started, round_done, no_progress, overflow}, 32'd0);
        rst_n = 1'b1;
        tick();

        load_test_set();

        // Round 1
        step(1'b1, 1'b0, '0);                 // H0 recirculates
        check("after_h0_dout", {16'b0, dout}, 32'h0003);
        check("first_h0_no_round", {31'b0, round_done}, 32'd0);
        step(1'b1, 1'b0, '0);                 // 0011 eliminated
        step(1'b1, 1'b0, '0);                 // 0110 popped
        step(1'b1, 1'b0, '0);                 // 1100 eliminated
        step(1'b1, 1'b1, 16'h0006);           // H1 pop + put-back 0110
        check("cnt0_after_pass", {25'b0, cnt(0)}, 32'd1);
        step(1'b1, 1'b1, 16'h0003);           // line 1 survivor
        step(1'b1, 1'b0, '0);                 // H0 closes round 1
        check("round1_done", {31'b0, round_done}, 32'd1);
        check("round1_progress", {31'b0, no_progress}, 32'd0);
        check("cnt1_after_pass", {25'b0, cnt(1)}, 32'd1);

        // Round 2 with identical survivors
        step(1'b1, 1'b1, 16'h0006);
        check("round_done_pulse", {31'b0, round_done}, 32'd0);
        step(1'b1, 1'b0, '0);                 // H1
        step(1'b1, 1'b1, 16'h0003);
        step(1'b1, 1'b0, '0);                 // H0 closes round 2
        check("round2_done", {31'b0, round_done}, 32'd1);
        check("no_progress_set", {31'b0, no_progress}, 32'd1);

        // Drain to H0,H1 then fill the queue completely
        step(1'b1, 1'b0, '0);                 // 0110 eliminated
        step(1'b1, 1'b0, '0);                 // H1 closes line 0 with no survivors
        check("cnt0_zero", {25'b0, cnt(0)}, 32'd0);
        step(1'b1, 1'b0, '0);                 // 0011 eliminated
        for (int i = 0; i < DEPTH - 2; i++) begin
            step(1'b0, 1'b1, 16'(i + 16'h0100));
        end
        check("full_no_overflow", {31'b0, overflow}, 32'd0);
        check("full_not_empty", {31'b0, empty}, 32'd0);
        step(1'b1, 1'b1, 16'hBEEF);           // header dropped, put-back kept
        check("overflow_set", {31'b0, overflow}, {31'b0, ovf_exp});
        check("overflow_exp", {31'b0, overflow}, 32'd1);
        check("cnt1_saturated", {25'b0, cnt(1)}, 32'd127);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, '0);             // H1 then the oldest put-backs
        end
        check("overflow_sticky", {31'b0, overflow}, 32'd1);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_empty", {31'b0, empty}, 32'd1);
        check("arst_dout", {15'b0, dout_is_header, dout}, 32'd0);
        check("arst_cnt0", {25'b0, cnt(0)}, 32'd0);
        check("arst_cnt1", {25'b0, cnt(1)}, 32'd0);
        check("arst_flags", {29'b0, round_done, no_progress, overflow}, 32'd0);
        sb.delete();
        ovf_exp = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        load_test_set();
        step(1'b1, 1'b0, '0);
        check("reload_after_h0", {16'b0, dout}, 32'h0003);
        step(1'b1, 1'b0, '0);
        check("reload_overflow", {31'b0, overflow}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
